// File: rtl/serial_add_sub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM encoding, select codes, default width.
package serial_add_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_cell.sv
// One-bit full adder/subtractor: b is inverted by sel, so subtract is a + ~b + cin.
// Purely combinational, zero latency, no flow control.
module add_sub_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic sum,
  output logic cout
);

  logic bx;

  assign bx   = b ^ sel;
  assign sum  = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/sub, LSB first through one cell; done pulses WIDTH+1 cycles after start.
// No queuing: start is only sampled in IDLE, so a request while busy is simply dropped.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic [CW-1:0]    cnt_q;
  logic             sel_q, carry_q;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic             sum_w, cy_w;

  add_sub_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sel  (sel_q),
    .sum  (sum_w),
    .cout (cy_w)
  );

  assign a_d   = a_q >> 1;
  assign b_d   = b_q >> 1;
  assign res_d = {sum_w, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= SEL_ADD;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sel_q   <= sel;
            carry_q <= sel;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q   <= res_d;
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= cy_w;
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB, cy_w the carry out of it
            cout_q  <= cy_w;
            ovf_q   <= carry_q ^ cy_w;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8): arithmetic corners, timing, ignored starts, mid-op reset.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         sel;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept at the first posedge, then walk cycles 1..9 on negedges.
  // With inject set, competing starts are raised in cycles 3 and 9.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input bit inject, input string tag);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; sel = ts;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (inject && (k == 3 || k == W + 1)) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; sel = 1'b1;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
      end
      if (k <= W) begin
        if (busy !== 1'b1 || done !== 1'b0) check({tag, "_busy_phase"}, {busy, done}, 2'b10);
      end else begin
        check({tag, "_done"},     done,     1'b1);
        check({tag, "_busy_off"}, busy,     1'b0);
        check({tag, "_result"},   result,   er);
        check({tag, "_cout"},     cout,     ec);
        check({tag, "_overflow"}, overflow, eo);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_cout_ovf", {cout, overflow}, 2'b00);
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, "add_5_3");
    do_op(8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, "sub_5_3");
    do_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_3_5");
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "add_7f_1");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "add_ff_1");
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_80_1");
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "add_80_80");
    do_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "add_ff_ff");
    do_op(8'hA5, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "sub_equal");

    // idle hold: result and flags stay after done
    repeat (4) @(negedge clk);
    check("hold_result", result, 8'h00);
    check("hold_flags", {cout, overflow, done, busy}, 4'b1000);

    // competing starts in cycles 3 and 9 are dropped; cycle 10 start is taken
    do_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, "ignore_start");
    do_op(8'h10, 8'h22, 1'b0, 8'h32, 1'b0, 1'b0, 1'b0, "accept_c10");
    @(negedge clk);
    check("single_done", done, 1'b0);

    // reset during cycle 4 of SHIFT
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h11; sel = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_flags", {cout, overflow}, 2'b00);
    rst_n = 1'b1;
    begin
      bit seen_done = 1'b0;
      repeat (W + 3) begin
        @(negedge clk);
        if (done) seen_done = 1'b1;
      end
      check("midrst_no_done", seen_done, 1'b0);
    end
    do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
